// File: rtl/fifo_status_monitor.sv
// Occupancy, empty/full, almost-full and sticky error tracking for the five
// transaction-layer FIFOs (MF, VC0, VC1, D0, D1), derived from push/pop strobes.
module fifo_status_monitor #(
    parameter int DEPTH = 8,
    parameter int CW    = 4,
    parameter int U_MFS = 4,
    parameter int U_VCS = 4,
    parameter int U_DS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_umbrales,
    input  logic [U_MFS-1:0]  umbral_MFs,
    input  logic [U_VCS-1:0]  umbral_VCs,
    input  logic [U_DS-1:0]   umbral_Ds,
    input  logic [4:0]        push,
    input  logic [4:0]        pop,
    input  logic              err_clr,
    output logic [4:0]        FIFO_empties,
    output logic [4:0]        FIFO_errors,
    output logic [4:0]        almost_full,
    output logic [4:0]        full,
    output logic [5*CW-1:0]   occupancy
);

    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

    logic [CW-1:0]    r_cnt [5];
    logic [U_MFS-1:0] r_umb_mf;
    logic [U_VCS-1:0] r_umb_vc;
    logic [U_DS-1:0]  r_umb_d;

    logic [CW-1:0]    w_cnt_nxt [5];
    logic [4:0]       w_evt;
    logic [U_MFS-1:0] w_umb_mf_nxt;
    logic [U_VCS-1:0] w_umb_vc_nxt;
    logic [U_DS-1:0]  w_umb_d_nxt;
    logic [31:0]      w_thr [5];
    logic [4:0]       w_empty_nxt;
    logic [4:0]       w_full_nxt;
    logic [4:0]       w_af_nxt;

    // A zero threshold means DEPTH; anything above DEPTH can never be reached.
    function automatic logic [31:0] eff_thr(input logic [31:0] t);
        return (t == 32'd0) ? 32'(DEPTH) : t;
    endfunction

    always_comb begin
        w_umb_mf_nxt = load_umbrales ? umbral_MFs : r_umb_mf;
        w_umb_vc_nxt = load_umbrales ? umbral_VCs : r_umb_vc;
        w_umb_d_nxt  = load_umbrales ? umbral_Ds  : r_umb_d;

        w_thr[0] = eff_thr(32'(w_umb_mf_nxt));
        w_thr[1] = eff_thr(32'(w_umb_vc_nxt));
        w_thr[2] = w_thr[1];
        w_thr[3] = eff_thr(32'(w_umb_d_nxt));
        w_thr[4] = w_thr[3];

        w_evt       = '0;
        w_empty_nxt = '0;
        w_full_nxt  = '0;
        w_af_nxt    = '0;
        for (int i = 0; i < 5; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            case ({push[i], pop[i]})
                2'b10: begin
                    if (r_cnt[i] == LP_DEPTH) w_evt[i] = 1'b1;
                    else                      w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
                2'b01: begin
                    if (r_cnt[i] == '0) w_evt[i] = 1'b1;
                    else                w_cnt_nxt[i] = r_cnt[i] - CW'(1);
                end
                2'b11: begin
                    // Pop of an empty FIFO with a same-cycle push still underflows.
                    if (r_cnt[i] == '0) begin
                        w_cnt_nxt[i] = CW'(1);
                        w_evt[i]     = 1'b1;
                    end
                end
                default: ;
            endcase
            w_empty_nxt[i] = (w_cnt_nxt[i] == '0);
            w_full_nxt[i]  = (w_cnt_nxt[i] == LP_DEPTH);
            w_af_nxt[i]    = (32'(w_cnt_nxt[i]) >= w_thr[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
            r_umb_mf     <= U_MFS'(DEPTH);
            r_umb_vc     <= U_VCS'(DEPTH);
            r_umb_d      <= U_DS'(DEPTH);
            FIFO_empties <= '1;
            FIFO_errors  <= '0;
            almost_full  <= '0;
            full         <= '0;
        end else begin
            for (int i = 0; i < 5; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_umb_mf     <= w_umb_mf_nxt;
            r_umb_vc     <= w_umb_vc_nxt;
            r_umb_d      <= w_umb_d_nxt;
            FIFO_empties <= w_empty_nxt;
            FIFO_errors  <= err_clr ? w_evt : (FIFO_errors | w_evt);
            almost_full  <= w_af_nxt;
            full         <= w_full_nxt;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < 5; i++) occupancy[i*CW +: CW] = r_cnt[i];
    end

endmodule

// File: tb/tb_fifo_status_monitor.sv
// Directed-vector bench for fifo_status_monitor: stimulus queues hand-computed
// expectations, a monitor process compares them one cycle after each edge.
module tb_fifo_status_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_umbrales;
    logic [3:0]  umbral_MFs, umbral_VCs, umbral_Ds;
    logic [4:0]  push, pop;
    logic        err_clr;
    logic [4:0]  FIFO_empties, FIFO_errors, almost_full, full;
    logic [19:0] occupancy;

    fifo_status_monitor #(.DEPTH(8), .CW(4), .U_MFS(4), .U_VCS(4), .U_DS(4)) dut (
        .clk(clk), .reset(reset), .load_umbrales(load_umbrales),
        .umbral_MFs(umbral_MFs), .umbral_VCs(umbral_VCs), .umbral_Ds(umbral_Ds),
        .push(push), .pop(pop), .err_clr(err_clr),
        .FIFO_empties(FIFO_empties), .FIFO_errors(FIFO_errors),
        .almost_full(almost_full), .full(full), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          cyc;
        logic [4:0]  emp, err, af, fl;
        logic [19:0] occ;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every falling edge, check whatever expectations target this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc || FIFO_empties !== e.emp || FIFO_errors !== e.err ||
                almost_full !== e.af || full !== e.fl || occupancy !== e.occ) begin
                n_bad++;
                $display("FAIL %s: got emp=%b err=%b af=%b full=%b occ=%h, want emp=%b err=%b af=%b full=%b occ=%h",
                         e.nm, FIFO_empties, FIFO_errors, almost_full, full, occupancy,
                         e.emp, e.err, e.af, e.fl, e.occ);
            end
        end
    end

    task automatic apply(input string nm, input logic ld, input logic [3:0] umf,
                         input logic [3:0] uvc, input logic [3:0] ud,
                         input logic [4:0] ps, input logic [4:0] pp,
                         input logic clr, input logic rs,
                         input logic [4:0] e_emp, input logic [4:0] e_err,
                         input logic [4:0] e_af, input logic [4:0] e_fl,
                         input logic [19:0] e_occ);
        exp_t e;
        load_umbrales = ld;
        umbral_MFs    = umf;
        umbral_VCs    = uvc;
        umbral_Ds     = ud;
        push          = ps;
        pop           = pp;
        err_clr       = clr;
        reset         = rs;
        e.nm  = nm;
        e.cyc = cyc + 1;
        e.emp = e_emp;
        e.err = e_err;
        e.af  = e_af;
        e.fl  = e_fl;
        e.occ = e_occ;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; load_umbrales = 1'b0; umbral_MFs = '0; umbral_VCs = '0;
        umbral_Ds = '0; push = '0; pop = '0; err_clr = 1'b0;
        @(posedge clk);
        #1;

        apply("reset", 0, 0, 0, 0, 5'b0, 5'b0, 0, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 20'h00000);
        for (int k = 0; k < 3; k++)
            apply("idle", 0, 0, 0, 0, 5'b0, 5'b0, 0, 0, 5'h1F, 5'h00, 5'h00, 5'h00, 20'h00000);

        // MF threshold 3, then three pushes on MF.
        apply("load_mf3", 1, 4'd3, 4'd8, 4'd8, 5'b0, 5'b0, 0, 0, 5'h1F, 5'h00, 5'h00, 5'h00, 20'h00000);
        apply("mf_push1", 0, 0, 0, 0, 5'b00001, 5'b0, 0, 0, 5'b11110, 5'h00, 5'h00, 5'h00, 20'h00001);
        apply("mf_push2", 0, 0, 0, 0, 5'b00001, 5'b0, 0, 0, 5'b11110, 5'h00, 5'h00, 5'h00, 20'h00002);
        apply("mf_af3",   0, 0, 0, 0, 5'b00001, 5'b0, 0, 0, 5'b11110, 5'h00, 5'b00001, 5'h00, 20'h00003);

        // D0 pushed 9 times: full on the 8th, overflow on the 9th.
        for (int k = 1; k <= 8; k++)
            apply("d0_fill", 0, 0, 0, 0, 5'b01000, 5'b0, 0, 0, 5'b10110, 5'h00,
                  (k == 8) ? 5'b01001 : 5'b00001, (k == 8) ? 5'b01000 : 5'b00000,
                  20'h00003 | (20'(k) << 12));
        apply("d0_ovf", 0, 0, 0, 0, 5'b01000, 5'b0, 0, 0, 5'b10110, 5'b01000, 5'b01001, 5'b01000, 20'h08003);

        // VC1 underflow concurrent with err_clr: new event wins.
        apply("vc1_udf_clr", 0, 0, 0, 0, 5'b0, 5'b00100, 1, 0, 5'b10110, 5'b00100, 5'b01001, 5'b01000, 20'h08003);
        apply("err_clr",     0, 0, 0, 0, 5'b0, 5'b0,     1, 0, 5'b10110, 5'b00000, 5'b01001, 5'b01000, 20'h08003);

        // MF to 8, then push+pop at full.
        for (int k = 4; k <= 8; k++)
            apply("mf_fill", 0, 0, 0, 0, 5'b00001, 5'b0, 0, 0, 5'b10110, 5'h00, 5'b01001,
                  (k == 8) ? 5'b01001 : 5'b01000, 20'h08000 | 20'(k));
        apply("mf_pp_full", 0, 0, 0, 0, 5'b00001, 5'b00001, 0, 0, 5'b10110, 5'h00, 5'b01001, 5'b01001, 20'h08008);

        // Drain MF to 0, then push+pop at empty.
        for (int k = 7; k >= 0; k--)
            apply("mf_drain", 0, 0, 0, 0, 5'b0, 5'b00001, 0, 0,
                  (k == 0) ? 5'b10111 : 5'b10110, 5'h00,
                  (k >= 3) ? 5'b01001 : 5'b01000, 5'b01000, 20'h08000 | 20'(k));
        apply("mf_pp_empty", 0, 0, 0, 0, 5'b00001, 5'b00001, 0, 0, 5'b10110, 5'b00001, 5'b01000, 5'b01000, 20'h08001);

        // Multi-FIFO strobes with thresholds MF=5, VC=0 (->8), D=9 (never).
        apply("multi_load", 1, 4'd5, 4'd0, 4'd9, 5'b10011, 5'b01000, 0, 0, 5'b00100, 5'b00001, 5'h00, 5'h00, 20'h17012);
        apply("mf_vc0_push", 0, 0, 0, 0, 5'b00011, 5'b0, 0, 0, 5'b00100, 5'b00001, 5'h00, 5'h00, 20'h17023);
        apply("mf_push4",    0, 0, 0, 0, 5'b00001, 5'b0, 0, 0, 5'b00100, 5'b00001, 5'h00, 5'h00, 20'h17024);
        apply("mf_af5",      0, 0, 0, 0, 5'b00001, 5'b0, 0, 0, 5'b00100, 5'b00001, 5'b00001, 5'h00, 20'h17025);
        apply("d_never_af",  0, 0, 0, 0, 5'b01000, 5'b0, 0, 0, 5'b00100, 5'b00001, 5'b00001, 5'b01000, 20'h18025);
        apply("vc0_pp_mid",  0, 0, 0, 0, 5'b00010, 5'b01010, 0, 0, 5'b00100, 5'b00001, 5'b00001, 5'h00, 20'h17025);

        // Reset mid-traffic with counts 5/2/0/7/1, strobes asserted alongside.
        apply("reset_mid", 1, 4'd1, 4'd1, 4'd1, 5'b11111, 5'b00000, 0, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 20'h00000);

        // Thresholds back to DEPTH: almost_full only at 8.
        for (int k = 1; k <= 8; k++)
            apply("all_fill", 0, 0, 0, 0, 5'b11111, 5'b0, 0, 0, 5'h00, 5'h00,
                  (k == 8) ? 5'h1F : 5'h00, (k == 8) ? 5'h1F : 5'h00, 20'h11111 * 20'(k));
        apply("all_ovf", 0, 0, 0, 0, 5'b11111, 5'b0, 0, 0, 5'h00, 5'h1F, 5'h1F, 5'h1F, 20'h88888);

        push = '0;
        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending checks, want 0", q.size());
            n_bad += q.size();
            n_vec += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, want completion before 100000");
        $fatal(1);
    end

endmodule

// File: doc/fifo_status_monitor.md
Name: fifo_status_monitor

Overview:
- Tracks the occupancy of the five transaction-layer FIFOs from their push/pop strobes: main FIFO (MF), two virtual-channel FIFOs (VC0, VC1) and two destination FIFOs (D0, D1).
- Produces the empty flags and sticky error flags that the transaction-layer state machine consumes as FIFO_empties / FIFO_errors.
- Produces per-FIFO almost-full flags against the programmed thresholds (umbrales).
- Sits between the FIFO datapath and the control state machine, so that the control FSM never inspects FIFO internals.

Parameters:
- DEPTH, 8, entries per FIFO; all five FIFOs have the same depth.
- CW, 4, occupancy counter width; must hold 0..DEPTH (CW >= clog2(DEPTH+1)).
- U_MFS, 4, width of the MF threshold.
- U_VCS, 4, width of each VC threshold.
- U_DS, 4, width of each D threshold.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_umbrales  in  1  while high, latches the three threshold inputs.
- umbral_MFs  in  U_MFS  almost-full threshold for the MF FIFO (bit index 0).
- umbral_VCs  in  U_VCS  almost-full threshold for VC0 and VC1 (bit indices 1, 2).
- umbral_Ds  in  U_DS  almost-full threshold for D0 and D1 (bit indices 3, 4).
- push  in  5  per-FIFO write strobe; index order is MF, VC0, VC1, D0, D1.
- pop  in  5  per-FIFO read strobe; same index order.
- err_clr  in  1  clears all sticky error bits.
- FIFO_empties  out  5  bit i = 1 when FIFO i occupancy is 0.
- FIFO_errors  out  5  sticky bit i = 1 after an overflow or underflow on FIFO i.
- almost_full  out  5  bit i = 1 when occupancy i >= threshold of its class.
- full  out  5  bit i = 1 when occupancy i == DEPTH.
- occupancy  out  5*CW  packed counters; FIFO i occupies bits [i*CW +: CW].

Behaviour:
- Reset (reset=1 at a clk edge):
  - all counters = 0; FIFO_empties = 5'b11111; FIFO_errors = 0; full = 0; almost_full = 0.
  - the three threshold registers load DEPTH, truncated to each threshold's width.
  - reset has priority over every other input.
- All outputs are registered. Flags and occupancy reflect the counter value after the current edge, so a strobe at edge N is visible in all outputs after edge N (one-cycle latency).
- Per-FIFO update rules, evaluated independently for each i:
  - push only, not full: count +1.
  - push only, full: count unchanged; overflow sets FIFO_errors[i].
  - pop only, not empty: count -1.
  - pop only, empty: count unchanged; underflow sets FIFO_errors[i].
  - push and pop, count strictly between 0 and DEPTH: count unchanged.
  - push and pop, full: count unchanged, no error (the pop frees the slot).
  - push and pop, empty: count becomes 1; underflow sets FIFO_errors[i].
  - neither strobe: count holds.
- Counters never wrap: no transition below 0 or above DEPTH.
- Thresholds:
  - Sampled on each edge where load_umbrales=1 and reset=0; otherwise they hold.
  - VC0 and VC1 share umbral_VCs; D0 and D1 share umbral_Ds.
  - A stored threshold of 0 is treated as DEPTH.
  - A threshold greater than DEPTH means almost_full never asserts for that class.
  - almost_full is computed against the newly loaded threshold in the same update as the load.
- Sticky errors:
  - err_clr=1 clears all FIFO_errors bits at the edge.
  - If a new overflow or underflow on FIFO i occurs at the same edge as err_clr, bit i ends at 1 (the new event wins).
  - Errors never change counter behaviour; counting continues normally after an error.
- Derived flags:
  - FIFO_empties[i] = (count_i == 0).
  - full[i] = (count_i == DEPTH).
  - almost_full[i] = (count_i >= effective threshold of its class).
- No internal state machine beyond the five counters, the five error bits and the three threshold registers. Any number of FIFOs may strobe simultaneously with no interaction between them.

Test Plan:
- Reset, then idle 3 cycles -> FIFO_empties=5'b11111, FIFO_errors=0, occupancy all 0, almost_full=0.
- load_umbrales with umbral_MFs=3, then push[0] for 3 cycles -> occupancy[0]=3, almost_full[0]=1 one cycle after the 3rd push, FIFO_empties[0]=0; the other FIFOs stay unchanged.
- Push D0 9 times (DEPTH=8) -> full[3]=1 after the 8th push, FIFO_errors[3]=1 after the 9th push, occupancy stays 8.
- Pop VC1 while empty together with err_clr=1 -> FIFO_errors[2]=1; next cycle with err_clr=1 and no strobes -> FIFO_errors=0.
- Simultaneous push and pop on MF at count 8 -> count stays 8, no error; at count 0 -> count becomes 1 and FIFO_errors[0]=1.
- Assert reset mid-traffic with counts 5/2/0/7/1 -> next cycle all counts 0, empties=5'b11111, errors=0, thresholds back to DEPTH.
